led_frame_sequencer: RTL and testbench

Single-clock controller that turns one strip-column stored in the 512x8 frame RAM into an APA102-style serial stream for the LED wheel. It owns the RAM read port (address, enable), runs a byte-level state machine that emits start frame, per-LED header plus three colour bytes, and end frame. It also generates the strip clock and data. It sits between the frame RAM read port and the strip pins, and is triggered once per column by a start pulse.

---
 rtl/led_wheel_pkg.sv | 21 ++
 rtl/led_frame_sequencer_if.sv | 12 +
 rtl/led_frame_sequencer_bit_serializer.sv | 71 +++++++
 rtl/led_frame_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_led_frame_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_wheel_pkg.sv
// rtl/led_wheel_pkg.sv - shared state type, frame constants and sizing helper for the LED wheel sequencer
package led_wheel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_HDR,
        ST_PIX,
        ST_END
    } seq_state_t;

    localparam int         START_BYTES = 4;
    localparam logic [2:0] HDR_MARK    = 3'b111;
    localparam logic [7:0] END_FILL    = 8'hFF;

    // One 0xFF byte per 16 LEDs keeps the clock running long enough to push the last pixel out.
    function automatic int end_bytes(input int n_leds);
        return (n_leds + 15) / 16;
    endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// rtl/led_frame_sequencer_if.sv - frame RAM read port between the sequencer and the column RAM
interface led_frame_sequencer_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output raddr, output read_en, input rdata);
    modport slave  (input raddr, input read_en, output rdata);
endinterface

// File: rtl/led_frame_sequencer_bit_serializer.sv
// rtl/led_frame_sequencer_bit_serializer.sv - bit-cell timer, MSB-first shifter and strip clock/data generation
module led_bit_serializer #(
    parameter int HALF_PERIOD = 2
) (
    input  logic       clk_sys,
    input  logic       n_reset,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       led_clk_o,
    output logic       led_data_o,
    output logic       bit0_first_o,
    output logic       byte_done_o
);
    localparam int CELL  = 2 * HALF_PERIOD;
    localparam int CNT_W = (CELL > 1) ? $clog2(CELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(HALF_PERIOD);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             active_q;
    logic             clk_q;
    logic             last_cycle;

    assign cnt_inc      = cnt_q + 1'b1;
    assign last_cycle   = active_q && (cnt_q == CNT_LAST);
    assign byte_done_o  = last_cycle && (bit_q == 3'd0);
    assign bit0_first_o = active_q && (bit_q == 3'd0) && (cnt_q == '0);
    assign led_clk_o    = clk_q;
    assign led_data_o   = shift_q[7];

    // A load on the last cycle of a byte takes priority, which is what makes the stream gapless.
    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            active_q <= 1'b0;
            clk_q    <= 1'b0;
        end else if (clear_i) begin
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            active_q <= 1'b0;
            clk_q    <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= '0;
            bit_q    <= 3'd7;
            shift_q  <= byte_i;
            active_q <= 1'b1;
            clk_q    <= 1'b0;
        end else if (last_cycle) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
            if (bit_q == 3'd0) begin
                active_q <= 1'b0;
                shift_q  <= 8'h00;
            end else begin
                shift_q <= {shift_q[6:0], 1'b0};
                bit_q   <= bit_q - 3'd1;
            end
        end else if (active_q) begin
            cnt_q <= cnt_inc;
            clk_q <= (cnt_inc >= CNT_HIGH);
        end
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// rtl/led_frame_sequencer.sv - column-to-APA102 frame sequencer: FSM, counters, RAM fetch and holding register
// Optional abort input enabled by defining LED_SEQ_ABORT_EN.
module led_frame_sequencer
    import led_wheel_pkg::*;
#(
    parameter int N_LEDS      = 160,
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 8,
    parameter int HALF_PERIOD = 2
) (
    input  logic                  clk_sys,
    input  logic                  n_reset,
    input  logic                  start,
    input  logic [4:0]            brightness,
`ifdef LED_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    led_frame_sequencer_if.master ram,
    output logic                  led_clk,
    output logic                  led_data,
    output logic                  busy,
    output logic                  done
);
    localparam int END_BYTES = end_bytes(N_LEDS);
    localparam int BYTE_MAX  = (END_BYTES > START_BYTES) ? END_BYTES : START_BYTES;
    localparam int BYTE_W    = $clog2(BYTE_MAX);
    localparam int LED_W     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    generate
        if (3 * N_LEDS > 2 ** ADDR_WIDTH) begin : g_size_check
            $error("led_frame_sequencer: 3*N_LEDS does not fit in the RAM address space");
        end
        if (DATA_WIDTH != 8 || HALF_PERIOD < 1) begin : g_param_check
            $error("led_frame_sequencer: DATA_WIDTH must be 8 and HALF_PERIOD at least 1");
        end
    endgenerate

    seq_state_t            state_q, state_d;
    logic [LED_W-1:0]      led_q, led_d;
    logic [BYTE_W-1:0]     byte_q, byte_d;
    logic [4:0]            bright_q, bright_d;
    logic [7:0]            hold_q;
    logic                  rd_valid_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic                  done_q, done_d;

    logic                  ser_load, ser_clear, ser_bit0_first, ser_byte_done;
    logic [7:0]            ser_byte, pix_byte, hdr_byte;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] fetch_addr;

    led_bit_serializer #(.HALF_PERIOD(HALF_PERIOD)) u_serializer (
        .clk_sys      (clk_sys),
        .n_reset      (n_reset),
        .clear_i      (ser_clear),
        .load_i       (ser_load),
        .byte_i       (ser_byte),
        .led_clk_o    (led_clk),
        .led_data_o   (led_data),
        .bit0_first_o (ser_bit0_first),
        .byte_done_o  (ser_byte_done)
    );

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        byte_d     = byte_q;
        bright_d   = bright_q;
        done_d     = 1'b0;
        ser_load   = 1'b0;
        ser_clear  = 1'b0;
        ser_byte   = 8'h00;
        read_en    = 1'b0;
        // When the fetch lands on the byte boundary itself the holding register is still stale.
        pix_byte   = rd_valid_q ? ram.rdata : hold_q;
        hdr_byte   = {HDR_MARK, bright_q};
        fetch_addr = ADDR_WIDTH'(32'(led_q) * 3 + ((state_q == ST_PIX) ? 32'(byte_q) + 1 : 0));

        unique case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    bright_d = brightness;
                    led_d    = '0;
                    byte_d   = '0;
                    state_d  = ST_START;
                    ser_load = 1'b1;
                end
            end
            ST_START: begin
                if (ser_byte_done) begin
                    ser_load = 1'b1;
                    if (byte_q == BYTE_W'(START_BYTES - 1)) begin
                        state_d  = ST_HDR;
                        byte_d   = '0;
                        ser_byte = hdr_byte;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
            ST_HDR: begin
                read_en = ser_bit0_first;
                if (ser_byte_done) begin
                    state_d  = ST_PIX;
                    byte_d   = '0;
                    ser_load = 1'b1;
                    ser_byte = pix_byte;
                end
            end
            ST_PIX: begin
                read_en = ser_bit0_first && (byte_q != BYTE_W'(2));
                if (ser_byte_done) begin
                    ser_load = 1'b1;
                    if (byte_q == BYTE_W'(2)) begin
                        byte_d = '0;
                        if (led_q == LED_W'(N_LEDS - 1)) begin
                            state_d  = ST_END;
                            ser_byte = END_FILL;
                        end else begin
                            led_d    = led_q + 1'b1;
                            state_d  = ST_HDR;
                            ser_byte = hdr_byte;
                        end
                    end else begin
                        byte_d   = byte_q + 1'b1;
                        ser_byte = pix_byte;
                    end
                end
            end
            ST_END: begin
                if (ser_byte_done) begin
                    if (byte_q == BYTE_W'(END_BYTES - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        byte_d   = byte_q + 1'b1;
                        ser_load = 1'b1;
                        ser_byte = END_FILL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef LED_SEQ_ABORT_EN
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            ser_clear = 1'b1;
            ser_load  = 1'b0;
            read_en   = 1'b0;
            done_d    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            led_q      <= '0;
            byte_q     <= '0;
            bright_q   <= 5'd0;
            hold_q     <= 8'h00;
            rd_valid_q <= 1'b0;
            raddr_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            byte_q     <= byte_d;
            bright_q   <= bright_d;
            rd_valid_q <= read_en;
            done_q     <= done_d;
            if (read_en) begin
                raddr_q <= fetch_addr;
            end
            if (rd_valid_q) begin
                hold_q <= ram.rdata;
            end
        end
    end

    assign ram.read_en = read_en;
    assign ram.raddr   = read_en ? fetch_addr : raddr_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb/tb_led_frame_sequencer.sv - randomized self-checking bench for led_frame_sequencer against a bitstream model
`timescale 1ns/1ps
module tb_led_frame_sequencer;
    localparam int NA  = 2;
    localparam int HPA = 1;
    localparam int NB  = 3;
    localparam int HPB = 3;
    localparam int AW  = 9;

    logic clk_sys = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic [4:0] bright_a = 5'd0, bright_b = 5'd0;
`ifdef LED_SEQ_ABORT_EN
    logic       abort_a = 1'b0, abort_b = 1'b0;
`endif
    logic a_clk, a_data, a_busy, a_done;
    logic b_clk, b_data, b_busy, b_done;

    led_frame_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) ram_a ();
    led_frame_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) ram_b ();

    led_frame_sequencer #(.N_LEDS(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(8), .HALF_PERIOD(HPA)) dut_a (
        .clk_sys(clk_sys), .n_reset(n_reset), .start(start_a), .brightness(bright_a),
`ifdef LED_SEQ_ABORT_EN
        .abort(abort_a),
`endif
        .ram(ram_a), .led_clk(a_clk), .led_data(a_data), .busy(a_busy), .done(a_done)
    );

    led_frame_sequencer #(.N_LEDS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(8), .HALF_PERIOD(HPB)) dut_b (
        .clk_sys(clk_sys), .n_reset(n_reset), .start(start_b), .brightness(bright_b),
`ifdef LED_SEQ_ABORT_EN
        .abort(abort_b),
`endif
        .ram(ram_b), .led_clk(b_clk), .led_data(b_data), .busy(b_busy), .done(b_done)
    );

    logic [7:0] mem_a [0:511];
    logic [7:0] mem_b [0:511];
    always @(posedge clk_sys) if (ram_a.read_en) ram_a.rdata <= mem_a[ram_a.raddr];
    always @(posedge clk_sys) if (ram_b.read_en) ram_b.rdata <= mem_b[ram_b.raddr];

    int sel = 0;
    logic o_clk, o_data, o_busy, o_done, o_rd;
    logic [AW-1:0] o_addr;
    assign o_clk  = (sel == 0) ? a_clk : b_clk;
    assign o_data = (sel == 0) ? a_data : b_data;
    assign o_busy = (sel == 0) ? a_busy : b_busy;
    assign o_done = (sel == 0) ? a_done : b_done;
    assign o_rd   = (sel == 0) ? ram_a.read_en : ram_b.read_en;
    assign o_addr = (sel == 0) ? ram_a.raddr : ram_b.raddr;

    int n_checks = 0;
    int n_fail   = 0;

    bit exp_bits[$];
    bit cap_bits[$];
    int cap_addrs[$];
    int cap_done_at, cap_phase_bad, cap_data_bad, cap_busy_bad;
    bit cap_timeout;
    logic [2:0] cap_end;

    function automatic int cur_hp();
        return (sel == 0) ? HPA : HPB;
    endfunction

    function automatic int cur_n();
        return (sel == 0) ? NA : NB;
    endfunction

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_bright(input logic [4:0] v);
        if (sel == 0) bright_a = v; else bright_b = v;
    endtask

    task automatic fill_mem(input bit counting);
        for (int k = 0; k < 512; k++) begin
            logic [7:0] v;
            v = counting ? 8'(k + 1) : 8'($urandom);
            if (sel == 0) mem_a[k] = v; else mem_b[k] = v;
        end
    endtask

    // Reference: the frame as a list of bytes, expanded MSB first.
    task automatic build_expected(input logic [4:0] br);
        logic [7:0] bytes_q[$];
        logic [7:0] hdr;
        logic [7:0] b;
        int n;
        n = cur_n();
        hdr = {3'b111, br};
        exp_bits.delete();
        repeat (4) bytes_q.push_back(8'h00);
        for (int k = 0; k < n; k++) begin
            bytes_q.push_back(hdr);
            for (int j = 0; j < 3; j++) bytes_q.push_back((sel == 0) ? mem_a[3*k+j] : mem_b[3*k+j]);
        end
        repeat ((n + 15) / 16) bytes_q.push_back(8'hFF);
        foreach (bytes_q[x]) begin
            b = bytes_q[x];
            for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        end
    endtask

    function automatic int bit_mismatches();
        int m = 0;
        if (cap_bits.size() != exp_bits.size()) m++;
        for (int i = 0; i < cap_bits.size() && i < exp_bits.size(); i++)
            if (cap_bits[i] != exp_bits[i]) m++;
        return m;
    endfunction

    function automatic int addr_mismatches();
        int m = 0;
        if (cap_addrs.size() != 3 * cur_n()) m++;
        foreach (cap_addrs[i]) if (cap_addrs[i] != i) m++;
        return m;
    endfunction

    // Sample i is taken mid-cycle t+i, where t is the edge that accepted start.
    task automatic capture_frame(input bit drive_start, input int inject_at, input int stop_bit);
        bit prev_clk, prev_data;
        int run, nrise, limit;
        cap_bits.delete(); cap_addrs.delete();
        cap_done_at = -1; cap_phase_bad = 0; cap_data_bad = 0; cap_busy_bad = 0;
        cap_timeout = 1'b0; cap_end = 3'b111;
        limit = exp_bits.size() * 2 * cur_hp() + 40;
        if (drive_start) begin
            @(posedge clk_sys); #1 set_start(1'b1);
            @(posedge clk_sys); #1 set_start(1'b0);
        end
        prev_clk = 1'b0; prev_data = 1'b0; run = 0; nrise = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk_sys);
            if (inject_at != 0 && i == inject_at) set_start(1'b1);
            if (inject_at != 0 && i == inject_at + 1) set_start(1'b0);
            if (o_done) begin
                cap_done_at = i;
                cap_end = {o_busy, o_clk, o_data};
                if (run != cur_hp()) cap_phase_bad++;
                break;
            end
            if (!o_busy) cap_busy_bad++;
            if (o_rd) cap_addrs.push_back(int'(o_addr));
            if (i == 1) run = 1;
            else if (o_clk == prev_clk) begin
                run++;
                if (o_clk && o_data != prev_data) cap_data_bad++;
            end else begin
                if (run != cur_hp()) cap_phase_bad++;
                if (o_clk && o_data != prev_data) cap_data_bad++;
                run = 1;
            end
            if (o_clk && !prev_clk) begin
                cap_bits.push_back(o_data);
                nrise++;
                if (stop_bit != 0 && nrise == stop_bit) break;
            end
            prev_clk = o_clk; prev_data = o_data;
        end
        if (cap_done_at < 0 && stop_bit == 0) cap_timeout = 1'b1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_reset = 1'b1;
        for (int c = 0; c < 100; c++) begin
            logic [27:0] outs;
            @(negedge clk_sys);
            outs = {a_clk, a_data, a_busy, a_done, ram_a.read_en, ram_a.raddr,
                    b_clk, b_data, b_busy, b_done, ram_b.read_en, ram_b.raddr};
            n_checks++;
            if (outs !== 28'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs=%h required 0", c, outs);
            end
        end
    endtask

    task automatic test_single_frame();
        sel = 0;
        fill_mem(1'b1);
        set_bright(5'h1F);
        build_expected(5'h1F);
        capture_frame(1'b1, 0, 0);
        n_checks++;
        if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout: no done within budget"); end
        n_checks++;
        if (cap_bits.size() !== 104) begin n_fail++; $display("FAIL single_bitcount: got %0d required 104", cap_bits.size()); end
        n_checks++;
        if (bit_mismatches() !== 0) begin n_fail++; $display("FAIL single_bits: %0d mismatches required 0", bit_mismatches()); end
        n_checks++;
        if (cap_done_at !== 209) begin n_fail++; $display("FAIL single_done_time: t+%0d required t+209", cap_done_at); end
        n_checks++;
        if (addr_mismatches() !== 0) begin n_fail++; $display("FAIL single_reads: %0d reads, %0d mismatches required 6 reads 0..5", cap_addrs.size(), addr_mismatches()); end
        n_checks++;
        if (cap_end !== 3'b000) begin n_fail++; $display("FAIL single_end_outputs: busy/clk/data=%b required 000", cap_end); end
        n_checks++;
        if (cap_busy_bad !== 0) begin n_fail++; $display("FAIL single_busy: busy low %0d cycles mid-frame required 0", cap_busy_bad); end
        @(negedge clk_sys);
        n_checks++;
        if (o_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: done=%b on next cycle required 0", o_done); end
    endtask

    task automatic test_random_frames();
        for (int r = 0; r < 4; r++) begin
            logic [4:0] br;
            sel = r % 2;
            br = 5'($urandom);
            fill_mem(1'b0);
            set_bright(br);
            build_expected(br);
            capture_frame(1'b1, 0, 0);
            n_checks++;
            if (bit_mismatches() !== 0) begin n_fail++; $display("FAIL random_bits[%0d]: %0d mismatches required 0", r, bit_mismatches()); end
            n_checks++;
            if (cap_done_at !== exp_bits.size() * 2 * cur_hp() + 1) begin
                n_fail++; $display("FAIL random_done_time[%0d]: t+%0d required t+%0d", r, cap_done_at, exp_bits.size() * 2 * cur_hp() + 1);
            end
            n_checks++;
            if (addr_mismatches() !== 0) begin n_fail++; $display("FAIL random_reads[%0d]: %0d mismatches required 0", r, addr_mismatches()); end
            @(negedge clk_sys);
        end
    endtask

    task automatic test_gapless();
        sel = 1;
        fill_mem(1'b0);
        set_bright(5'h0A);
        build_expected(5'h0A);
        capture_frame(1'b1, 0, 0);
        n_checks++;
        if (cap_phase_bad !== 0) begin n_fail++; $display("FAIL gapless_phases: %0d phases not %0d cycles, required 0", cap_phase_bad, HPB); end
        n_checks++;
        if (cap_data_bad !== 0) begin n_fail++; $display("FAIL gapless_data_stable: %0d changes while clk high, required 0", cap_data_bad); end
        n_checks++;
        if (bit_mismatches() !== 0) begin n_fail++; $display("FAIL gapless_bits: %0d mismatches required 0", bit_mismatches()); end
        @(negedge clk_sys);
    endtask

    task automatic test_start_during_busy();
        sel = 0;
        fill_mem(1'b1);
        set_bright(5'h1F);
        build_expected(5'h1F);
        capture_frame(1'b1, 50, 0);
        n_checks++;
        if (bit_mismatches() !== 0 || cap_done_at !== 209) begin
            n_fail++; $display("FAIL busy_start: mismatches=%0d done=t+%0d required 0 and t+209", bit_mismatches(), cap_done_at);
        end
        set_start(1'b1);
        @(negedge clk_sys);
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL start_on_done: busy=%b after start on done cycle required 0", o_busy); end
        @(posedge clk_sys); #1 set_start(1'b0);
        capture_frame(1'b0, 0, 0);
        n_checks++;
        if (bit_mismatches() !== 0 || cap_done_at !== 209) begin
            n_fail++; $display("FAIL start_after_done: mismatches=%0d done=t+%0d required 0 and t+209", bit_mismatches(), cap_done_at);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_reset_mid_frame();
        int stray;
        sel = 0;
        fill_mem(1'b0);
        set_bright(5'h03);
        build_expected(5'h03);
        capture_frame(1'b1, 0, 40);
        n_checks++;
        if (cap_bits.size() !== 40) begin n_fail++; $display("FAIL reset_mid_reach: %0d bits seen required 40", cap_bits.size()); end
        #1 n_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_clk, o_data, o_busy, o_done, o_rd} !== 5'b0) begin
            n_fail++; $display("FAIL reset_async: clk/data/busy/done/rd=%b required 00000", {o_clk, o_data, o_busy, o_done, o_rd});
        end
        repeat (2) @(negedge clk_sys);
        n_reset = 1'b1;
        stray = 0;
        repeat (20) begin @(negedge clk_sys); if (o_done || o_busy) stray++; end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL reset_no_done: %0d cycles with done/busy required 0", stray); end
        capture_frame(1'b1, 0, 0);
        n_checks++;
        if (bit_mismatches() !== 0 || cap_done_at !== exp_bits.size() * 2 * HPA + 1) begin
            n_fail++; $display("FAIL reset_next_frame: mismatches=%0d done=t+%0d required 0 and t+%0d", bit_mismatches(), cap_done_at, exp_bits.size() * 2 * HPA + 1);
        end
        @(negedge clk_sys);
    endtask

`ifdef LED_SEQ_ABORT_EN
    task automatic test_abort();
        int stray;
        sel = 1;
        fill_mem(1'b0);
        set_bright(5'h11);
        build_expected(5'h11);
        capture_frame(1'b1, 0, 60);
        abort_b = 1'b1;
        @(negedge clk_sys);
        abort_b = 1'b0;
        n_checks++;
        if ({o_clk, o_data, o_busy, o_done, o_rd} !== 5'b0) begin
            n_fail++; $display("FAIL abort_idle: clk/data/busy/done/rd=%b required 00000", {o_clk, o_data, o_busy, o_done, o_rd});
        end
        stray = 0;
        repeat (30) begin @(negedge clk_sys); if (o_done || o_busy) stray++; end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL abort_no_done: %0d cycles with done/busy required 0", stray); end
        capture_frame(1'b1, 0, 0);
        n_checks++;
        if (bit_mismatches() !== 0 || cap_done_at !== exp_bits.size() * 2 * HPB + 1) begin
            n_fail++; $display("FAIL abort_next_frame: mismatches=%0d done=t+%0d required 0 and t+%0d", bit_mismatches(), cap_done_at, exp_bits.size() * 2 * HPB + 1);
        end
        @(negedge clk_sys);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_gapless();
        test_start_during_busy();
        test_reset_mid_frame();
`ifdef LED_SEQ_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
